// File: rtl/csa_pkg.sv
// csa_pkg: shared types and sizing helpers for the carry-save accumulator.
//   state_t  : controller states (ACC fold operands, RES resolve, OUT present)
//   nchunk() : number of carry-propagate chunks needed to cover acc_w bits
//   idx_w()  : width of a chunk index, never less than 1
package csa_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RES = 2'd1,
    OUT = 2'd2
  } state_t;

  function automatic int unsigned nchunk(input int unsigned acc_w,
                                         input int unsigned cpa_w);
    return (acc_w + cpa_w - 1) / cpa_w;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sizing at the default ACC_W=32, CPA_W=8 configuration.
  localparam int unsigned NCHUNK_DEF = nchunk(32, 8);
  localparam int unsigned KW_DEF     = idx_w(NCHUNK_DEF);

endpackage

// File: rtl/csa_accum_pipe_row.sv
// csa_3to2_row: W-bit 3:2 carry-save compressor, purely combinational.
//   a, b, c : addend rows
//   s       : bitwise sum row (a ^ b ^ c)
//   cout    : majority carry row shifted left by one, LSB = 0, MSB carry dropped
module csa_3to2_row #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cout
);

  assign s    = a ^ b ^ c;
  assign cout = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_accum_pipe.sv
// csa_accum_pipe: streaming multi-operand accumulator with carry-save running
// total and a chunked multi-cycle carry-propagate resolve.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_data operand, in_last ends group
//   out_valid/out_ready : result handshake
//   out_data            : resolved group sum modulo 2^ACC_W
//   out_count           : operands in the group, saturating at 2^CNT_W-1
//   out_sat             : operand counter saturated during the group
module csa_accum_pipe
  import csa_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CPA_W  = 8,
  parameter int unsigned CNT_W  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam int unsigned NCHUNK = nchunk(ACC_W, CPA_W);
  localparam int unsigned KW     = idx_w(NCHUNK);
  // Rows are padded to whole chunks so the last, possibly narrower, chunk can
  // use the same fixed-width adder; the padding bits are zero.
  localparam int unsigned PW     = NCHUNK * CPA_W;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  state_t           state;
  logic [ACC_W-1:0] s_q, c_q, x, s_nx, c_nx;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic [KW-1:0]    k;
  logic             carry;
  logic [PW-1:0]    sp, cp, res, res_nx;
  logic [CPA_W-1:0] ca, cb;
  logic [CPA_W:0]   csum;
  logic             accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    x = (SIGNED && in_data[IN_W-1]) ? '1 : '0;
    x[IN_W-1:0] = in_data;
  end

  csa_3to2_row #(.W(ACC_W)) u_row (
    .a    (s_q),
    .b    (c_q),
    .c    (x),
    .s    (s_nx),
    .cout (c_nx)
  );

  always_comb begin
    int unsigned base;
    base = 32'(k) * CPA_W;
    sp = '0;
    cp = '0;
    sp[ACC_W-1:0] = s_q;
    cp[ACC_W-1:0] = c_q;
    ca = sp[base +: CPA_W];
    cb = cp[base +: CPA_W];
    csum = {1'b0, ca} + {1'b0, cb} + (CPA_W + 1)'(carry);
    res_nx = res;
    res_nx[base +: CPA_W] = csum[CPA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      s_q       <= '0;
      c_q       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      k         <= '0;
      carry     <= 1'b0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            s_q <= s_nx;
            c_q <= c_nx;
            if (count == '1) sat <= 1'b1;
            else             count <= count + CNT_W'(1);
            if (in_last) begin
              state    <= RES;
              k        <= '0;
              carry    <= 1'b0;
              in_ready <= 1'b0;
            end
          end
        end
        RES: begin
          res   <= res_nx;
          carry <= csum[CPA_W];
          k     <= k + KW'(1);
          if (k == KLAST) begin
            state     <= OUT;
            out_data  <= res_nx[ACC_W-1:0];
            out_count <= count;
            out_sat   <= sat;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            s_q       <= '0;
            c_q       <= '0;
            count     <= '0;
            sat       <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb_csa_accum_pipe: directed checks of three csa_accum_pipe configurations:
//   u0 defaults (unsigned, ACC_W=32), u1 SIGNED=1, u2 ACC_W=16/CPA_W=5/CNT_W=2.
module tb_csa_accum_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        ir0, ov0, os0;
  logic [31:0] od0;
  logic [7:0]  oc0;
  logic        ir1, ov1, os1;
  logic [31:0] od1;
  logic [7:0]  oc1;
  logic        ir2, ov2, os2;
  logic [15:0] od2;
  logic [1:0]  oc2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  csa_accum_pipe #(.IN_W(16), .ACC_W(32), .CPA_W(8), .CNT_W(8), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_count(oc0), .out_sat(os0));

  csa_accum_pipe #(.IN_W(16), .ACC_W(32), .CPA_W(8), .CNT_W(8), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_count(oc1), .out_sat(os1));

  csa_accum_pipe #(.IN_W(16), .ACC_W(16), .CPA_W(5), .CNT_W(2), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_count(oc2), .out_sat(os2));

  function automatic logic get_ir(input int w);
    case (w)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [31:0] get_od(input int w);
    case (w)
      0: return od0;
      1: return od1;
      default: return {16'h0, od2};
    endcase
  endfunction

  function automatic logic [31:0] get_oc(input int w);
    case (w)
      0: return {24'h0, oc0};
      1: return {24'h0, oc1};
      default: return {30'h0, oc2};
    endcase
  endfunction

  function automatic logic get_os(input int w);
    case (w)
      0: return os0;
      1: return os1;
      default: return os2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand to instance w once it is ready; accepted on the next edge.
  task automatic send(input int w, input logic [15:0] d, input logic l);
    int n = 0;
    while (!get_ir(w) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 32'(n < 50), 32'd1);
    in_data = d;
    in_last = l;
    iv      = 3'b000;
    iv[w]   = 1'b1;
    @(posedge clk); #1;
    iv      = 3'b000;
    in_last = 1'b0;
  endtask

  // Count edges until out_valid is seen (sampled 1 time unit after each edge).
  task automatic wait_out(input int w, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!get_ov(w) && cyc < 50);
    chk("out_valid_seen", 32'(get_ov(w)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    logic seen;
    logic [31:0] cap_d, cap_c;

    rst = 1'b1; iv = 3'b000; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", od0, 32'h0);
    chk("rst_out_count", 32'(oc0), 32'd0);
    chk("rst_out_sat", 32'(os0), 32'd0);
    chk("rst_u2_in_ready", 32'(ir2), 32'd1);
    #1 rst = 1'b0;

    // Three 0xFFFF operands, unsigned
    send(0, 16'hFFFF, 1'b0);
    send(0, 16'hFFFF, 1'b0);
    send(0, 16'hFFFF, 1'b1);
    wait_out(0, cyc);
    chk("t1_latency", 32'(cyc), 32'd4);
    chk("t1_data", od0, 32'h0002FFFD);
    chk("t1_count", get_oc(0), 32'd3);
    chk("t1_sat", 32'(os0), 32'd0);

    // Single operand; in_ready low for exactly 5 cycles with out_ready high
    send(0, 16'h1234, 1'b1);
    n = 0; cap_d = '0; cap_c = '0;
    while (!ir0 && n < 50) begin
      if (ov0) begin
        cap_d = od0;
        cap_c = get_oc(0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("t2_ready_low", 32'(n), 32'd5);
    chk("t2_data", cap_d, 32'h00001234);
    chk("t2_count", cap_c, 32'd1);

    // Backpressure for 6 cycles
    out_ready = 1'b0;
    send(0, 16'h0100, 1'b0);
    send(0, 16'h0200, 1'b1);
    wait_out(0, cyc);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(ov0), 32'd1);
      chk("bp_data", od0, 32'h00000300);
      chk("bp_count", get_oc(0), 32'd2);
      chk("bp_in_ready", 32'(ir0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", 32'(ov0), 32'd0);
    chk("bp_back_ready", 32'(ir0), 32'd1);
    chk("bp_data_hold", od0, 32'h00000300);
    send(0, 16'h0007, 1'b0);
    send(0, 16'h0008, 1'b1);
    wait_out(0, cyc);
    chk("bp_next_data", od0, 32'h0000000F);
    chk("bp_next_count", get_oc(0), 32'd2);

    // Reset during resolve at chunk index 2
    send(0, 16'h1111, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rres_valid", 32'(ov0), 32'd0);
    chk("rres_data", od0, 32'h0);
    chk("rres_count", get_oc(0), 32'd0);
    chk("rres_sat", 32'(os0), 32'd0);
    chk("rres_in_ready", 32'(ir0), 32'd1);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov0) seen = 1'b1;
    end
    chk("rres_no_output", 32'(seen), 32'd0);
    send(0, 16'h0010, 1'b0);
    send(0, 16'h0020, 1'b1);
    wait_out(0, cyc);
    chk("rres_next_data", od0, 32'h00000030);
    chk("rres_next_count", get_oc(0), 32'd2);

    // Signed operands: -1 + -1 + 5
    send(1, 16'hFFFF, 1'b0);
    send(1, 16'hFFFF, 1'b0);
    send(1, 16'h0005, 1'b1);
    wait_out(1, cyc);
    chk("sgn_latency", 32'(cyc), 32'd4);
    chk("sgn_data", od1, 32'h00000003);
    chk("sgn_count", get_oc(1), 32'd3);

    // 16-bit accumulator wraps
    send(2, 16'hFFFF, 1'b0);
    send(2, 16'h0002, 1'b1);
    wait_out(2, cyc);
    chk("wrap_latency", 32'(cyc), 32'd4);
    chk("wrap_data", get_od(2), 32'h00000001);
    chk("wrap_count", get_oc(2), 32'd2);
    chk("wrap_sat", 32'(get_os(2)), 32'd0);

    // 2-bit counter saturates on five operands
    for (int i = 0; i < 5; i++) send(2, 16'h0001, (i == 4));
    wait_out(2, cyc);
    chk("sat_data", get_od(2), 32'h00000005);
    chk("sat_count", get_oc(2), 32'd3);
    chk("sat_flag", 32'(get_os(2)), 32'd1);
    send(2, 16'h0003, 1'b0);
    send(2, 16'h0004, 1'b1);
    wait_out(2, cyc);
    chk("sat_next_data", get_od(2), 32'h00000007);
    chk("sat_next_count", get_oc(2), 32'd2);
    chk("sat_next_flag", 32'(get_os(2)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csa_accum_pipe.md
Name: csa_accum_pipe

Overview:
- Streaming multi-operand accumulator that keeps its running total in carry-save form (sum row plus carry row).
- Folds one operand per cycle through a parametrised 3:2 carry-save row.
- On the last operand of a group, resolves sum+carry with a multi-cycle chunked carry-propagate adder and presents the binary result on a valid/ready output.
- Sits between the partial-product generators and the final result register of the multiply/accumulate datapath.

Parameters:
- IN_W, 16, operand width.
- ACC_W, 32, accumulator and result width; must be >= IN_W.
- CPA_W, 8, bits resolved per cycle by the final adder; 1..ACC_W.
- CNT_W, 8, width of the operand counter.
- SIGNED, 0, 1 = operands sign-extended to ACC_W; 0 = zero-extended.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  IN_W  operand.
- in_last  in  1  operand is the final one of the group; qualified by an accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  resolved sum, modulo 2^ACC_W.
- out_count  out  CNT_W  number of operands in the group, saturating.
- out_sat  out  1  the counter saturated during this group.

Behaviour:
- Reset (async, active-high):
  - state=ACC; S=0, C=0, count=0, sat=0, chunk index=0, carry=0.
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_sat=0.
  - Reset asserted in any state aborts the group; no partial result is ever output.
- State ACC:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: X = ext(in_data) to ACC_W, where ext is sign- or zero-extension per SIGNED.
  - S <= S^C^X.
  - C <= (majority(S,C,X) << 1), truncated to ACC_W; the MSB carry is dropped.
  - count <= count+1, saturating at 2^CNT_W-1. sat <= 1 if an increment is attempted while count is already at max.
  - Accept with in_last=1: go to RES, chunk index k=0, carry=0.
  - The first operand of a group sees S=C=0.
- State RES:
  - in_ready=0.
  - Each cycle: res[chunk k] <= S[k]+C[k]+carry; carry <= chunk carry-out; k++.
  - The last chunk may be narrower than CPA_W when CPA_W does not divide ACC_W.
  - NCHUNK = ceil(ACC_W/CPA_W).
  - After chunk NCHUNK-1: go to OUT; out_data, out_count and out_sat are registered.
  - Final carry-out is discarded (mod 2^ACC_W).
- State OUT:
  - out_valid=1, in_ready=0.
  - out_data, out_count and out_sat hold stable until out_ready=1.
  - On out_valid & out_ready: go to ACC; S, C, count and sat clear to 0 on the same edge.
  - out_valid deasserts the next cycle; out_data holds its last value.
- Latency: in_last accepted at edge t gives out_valid high after edge t+NCHUNK (NCHUNK=4 at defaults). Minimum group turnaround is NCHUNK+1 cycles.
- Simultaneous events: a new operand cannot be accepted in the cycle out_ready completes, because in_ready is still 0. The next operand is accepted at the earliest one cycle later.
- in_valid while not in ACC is ignored. The upstream source must hold in_valid and in_data.
- Carry-save invariant: at all times in ACC, (S+C) mod 2^ACC_W equals the sum of the accepted operands mod 2^ACC_W.

Decomposition:
- Shared package csa_pkg:
  - state enum {ACC, RES, OUT};
  - function nchunk(ACC_W, CPA_W);
  - chunk-index width constant clog2(NCHUNK).
- Sub-module csa_3to2_row:
  - parametrised width W;
  - inputs A, B, C; outputs S and carry-out row Cout;
  - Cout is shifted left by one, LSB=0, truncated to W;
  - purely combinational; one instance on the ACC datapath.

Test Plan:
- Defaults, unsigned: 0xFFFF, 0xFFFF, 0xFFFF (last on third) -> out_data=0x0002FFFD, out_count=3, out_valid 4 cycles after the last accept.
- SIGNED=1: 0xFFFF, 0xFFFF, 0x0005 -> out_data=0x00000003; ACC_W=16, IN_W=16, unsigned: 0xFFFF, 0x0002 -> out_data=0x0001 (wrap).
- Single operand 0x1234 with in_last -> out_data=0x00001234, out_count=1; in_ready low for exactly 5 cycles when out_ready is tied high.
- Backpressure: out_ready held low 6 cycles -> out_valid, out_data and out_count stable, in_ready=0 throughout; a new group then accepts and returns the correct sum with no carry-over from the previous group.
- CNT_W=2, 5 operands of 1 -> out_data=5, out_count=3, out_sat=1; the following 2-operand group -> out_sat=0, out_count=2.
- rst pulsed during RES (k=2) -> all outputs 0 immediately, no out_valid; a subsequent group 0x0010, 0x0020 -> 0x00000030.
